// File: rtl/alu_flag_branch_unit.sv
// Consumer of the ALU flag interface: keeps the architectural NZCV register and
// produces a registered branch decision for B, B.cond, CBZ and CBNZ.
module alu_flag_branch_unit #(
  parameter int          BYPASS = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             set_flags,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       cond,
  output logic [3:0]       flags,
  output logic             flags_valid,
  output logic             take_branch,
  output logic             take_valid,
  output logic             cond_err,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {
    UNSET = 1'b0,
    SET   = 1'b1
  } flag_state_t;

  typedef enum logic [1:0] {
    BR_B    = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_type_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  flag_state_t state;
  logic        bypass_now;
  logic        flags_known;
  logic        eff_n, eff_z, eff_c, eff_v;
  logic        cond_base;
  logic        cond_ok;
  logic        decision;
  logic        err_now;

  always_comb begin
    bypass_now  = (BYPASS != 0) && set_flags;
    flags_known = (state == SET) || bypass_now;
    if (bypass_now) begin
      eff_n = alu_negative;
      eff_z = alu_zero;
      eff_c = alu_carry_out;
      eff_v = alu_overflow;
    end else begin
      eff_n = flags[3];
      eff_z = flags[2];
      eff_c = flags[1];
      eff_v = flags[0];
    end

    // Odd condition codes are the inverse of the preceding even one, except AL/NV.
    cond_base = 1'b1;
    case (cond[3:1])
      3'b000:  cond_base = eff_z;
      3'b001:  cond_base = eff_c;
      3'b010:  cond_base = eff_n;
      3'b011:  cond_base = eff_v;
      3'b100:  cond_base = eff_c & ~eff_z;
      3'b101:  cond_base = (eff_n == eff_v);
      3'b110:  cond_base = ~eff_z & (eff_n == eff_v);
      default: cond_base = 1'b1;
    endcase
    cond_ok = (cond[3:1] == 3'b111) ? 1'b1 : (cond_base ^ cond[0]);

    decision = 1'b0;
    err_now  = 1'b0;
    case (br_type_t'(br_type))
      BR_B:    decision = 1'b1;
      BR_COND: begin
        decision = flags_known & cond_ok;
        err_now  = ~flags_known;
      end
      BR_CBZ:  decision = alu_zero;
      BR_CBNZ: decision = ~alu_zero;
      default: decision = 1'b0;
    endcase
  end

  assign flags_valid = (state == SET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNSET;
      flags       <= '0;
      take_branch <= 1'b0;
      take_valid  <= 1'b0;
      cond_err    <= 1'b0;
      taken_count <= '0;
    end else begin
      if (set_flags) begin
        state <= SET;
        flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
      end

      take_valid <= br_valid;
      cond_err   <= br_valid & err_now;
      if (br_valid) begin
        take_branch <= decision;
        if (decision && (taken_count != '1))
          taken_count <= taken_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Bench for alu_flag_branch_unit: directed and random steps checked against a
// condition-table reference model, on a bypassing and a non-bypassing instance.
module tb_alu_flag_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic        set_flags, br_valid;
  logic [1:0]  br_type;
  logic [3:0]  cond;

  logic [3:0]  flags0, flags1;
  logic        fv0, fv1, tb0, tb1, tv0, tv1, ce0, ce1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance
  logic [3:0]  m_flags [2];
  bit          m_fset  [2];
  bit          m_tb    [2];
  bit          m_tv    [2];
  bit          m_err   [2];
  int unsigned m_cnt   [2];
  bit          m_bp    [2] = '{1'b1, 1'b0};
  int unsigned m_max   [2] = '{32'd65535, 32'd15};

  alu_flag_branch_unit #(.BYPASS(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .set_flags(set_flags), .br_valid(br_valid), .br_type(br_type), .cond(cond),
    .flags(flags0), .flags_valid(fv0), .take_branch(tb0), .take_valid(tv0),
    .cond_err(ce0), .taken_count(cnt0)
  );

  alu_flag_branch_unit #(.BYPASS(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .set_flags(set_flags), .br_valid(br_valid), .br_type(br_type), .cond(cond),
    .flags(flags1), .flags_valid(fv1), .take_branch(tb1), .take_valid(tv1),
    .cond_err(ce1), .taken_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cond_holds(input logic [3:0] cc, input bit n, z, c, v);
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < 2; i++) begin
      m_flags[i] = 4'b0000; m_fset[i] = 0; m_tb[i] = 0;
      m_tv[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit       n, z, c, v, known, dec;
    logic [3:0] alu_nzcv;
    alu_nzcv = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    for (int unsigned i = 0; i < 2; i++) begin
      known = m_fset[i] || (m_bp[i] && set_flags);
      if (m_bp[i] && set_flags) {n, z, c, v} = alu_nzcv;
      else                      {n, z, c, v} = m_flags[i];
      if (br_valid) begin
        m_tv[i]  = 1;
        m_err[i] = 0;
        case (br_type)
          2'd0: dec = 1;
          2'd1: begin
            dec      = known ? cond_holds(cond, n, z, c, v) : 1'b0;
            m_err[i] = !known;
          end
          2'd2: dec = alu_zero;
          default: dec = !alu_zero;
        endcase
        m_tb[i] = dec;
        if (dec && m_cnt[i] < m_max[i]) m_cnt[i]++;
      end else begin
        m_tv[i]  = 0;
        m_err[i] = 0;
      end
      if (set_flags) begin
        m_flags[i] = alu_nzcv;
        m_fset[i]  = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".flags0"}, 32'(flags0), 32'(m_flags[0]));
    chk({tag, ".fv0"},    32'(fv0),    32'(m_fset[0]));
    chk({tag, ".tb0"},    32'(tb0),    32'(m_tb[0]));
    chk({tag, ".tv0"},    32'(tv0),    32'(m_tv[0]));
    chk({tag, ".ce0"},    32'(ce0),    32'(m_err[0]));
    chk({tag, ".cnt0"},   32'(cnt0),   m_cnt[0]);
    chk({tag, ".flags1"}, 32'(flags1), 32'(m_flags[1]));
    chk({tag, ".fv1"},    32'(fv1),    32'(m_fset[1]));
    chk({tag, ".tb1"},    32'(tb1),    32'(m_tb[1]));
    chk({tag, ".tv1"},    32'(tv1),    32'(m_tv[1]));
    chk({tag, ".ce1"},    32'(ce1),    32'(m_err[1]));
    chk({tag, ".cnt1"},   32'(cnt1),   m_cnt[1]);
  endtask

  // alu_nzcv is {N,Z,C,V}
  task automatic step(input string tag, input bit sf, input logic [3:0] alu_nzcv,
                      input bit bv, input logic [1:0] bt, input logic [3:0] cc);
    set_flags     = sf;
    alu_negative  = alu_nzcv[3];
    alu_zero      = alu_nzcv[2];
    alu_carry_out = alu_nzcv[1];
    alu_overflow  = alu_nzcv[0];
    br_valid      = bv;
    br_type       = bt;
    cond          = cc;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] taken_cc [6] = '{4'd0, 4'd2, 4'd9, 4'd13, 4'd14, 4'd15};
    logic [3:0] nt_cc    [3] = '{4'd1, 4'd8, 4'd12};
    int unsigned cnt_before;

    set_flags = 0; br_valid = 0; br_type = 0; cond = 0;
    alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    #2;
    rst_n = 1'b1;

    // B.cond with flags never written
    step("bcond_unset", 0, 4'b0000, 1, 2'b01, 4'd0);
    chk("unset.tv", 32'(tv0), 32'd1);
    chk("unset.tb", 32'(tb0), 32'd0);
    chk("unset.ce", 32'(ce0), 32'd1);
    chk("unset.fv", 32'(fv0), 32'd0);

    // SUBS 5 - 7: N=1 Z=0 C=0 V=0
    step("subs_neg", 1, 4'b1000, 0, 2'b00, 4'd0);
    step("lt", 0, 4'b0000, 1, 2'b01, 4'd11);
    chk("lt.tb", 32'(tb0), 32'd1);
    step("ge", 0, 4'b0000, 1, 2'b01, 4'd10);
    chk("ge.tb", 32'(tb0), 32'd0);
    chk("ge.flags", 32'(flags0), 32'b1000);

    // SUBS 7 - 7: Z=1 C=1, then condition sweep
    step("subs_eq", 1, 4'b0110, 0, 2'b00, 4'd0);
    foreach (taken_cc[k]) begin
      cnt_before = 32'(cnt0);
      step("sweep_t", 0, 4'b0000, 1, 2'b01, taken_cc[k]);
      chk("sweep_t.tb", 32'(tb0), 32'd1);
      chk("sweep_t.cnt", 32'(cnt0), cnt_before + 1);
    end
    foreach (nt_cc[k]) begin
      cnt_before = 32'(cnt0);
      step("sweep_nt", 0, 4'b0000, 1, 2'b01, nt_cc[k]);
      chk("sweep_nt.tb", 32'(tb0), 32'd0);
      chk("sweep_nt.cnt", 32'(cnt0), cnt_before);
    end

    // Same-cycle set_flags Z=1 with B.cond EQ while stored Z=0
    step("clear_z", 1, 4'b0000, 0, 2'b00, 4'd0);
    step("bypass_eq", 1, 4'b0100, 1, 2'b01, 4'd0);
    chk("bypass1.tb", 32'(tb0), 32'd1);
    chk("bypass0.tb", 32'(tb1), 32'd0);
    chk("bypass1.z", 32'(flags0[2]), 32'd1);
    chk("bypass0.z", 32'(flags1[2]), 32'd1);
    step("idle", 0, 4'b0000, 0, 2'b00, 4'd0);
    chk("idle.tv", 32'(tv0), 32'd0);

    // Compare-and-branch and B are flag-state independent
    do_reset("reset2");
    step("cbz", 0, 4'b0100, 1, 2'b10, 4'd0);
    chk("cbz.tb", 32'(tb0), 32'd1);
    chk("cbz.ce", 32'(ce0), 32'd0);
    step("cbnz", 0, 4'b0100, 1, 2'b11, 4'd0);
    chk("cbnz.tb", 32'(tb0), 32'd0);
    chk("cbnz.fv", 32'(fv0), 32'd0);
    step("b", 0, 4'b0000, 1, 2'b00, 4'd7);
    chk("b.tb", 32'(tb0), 32'd1);

    // Random traffic, starting from UNSET
    do_reset("reset3");
    for (int unsigned r = 0; r < 400; r++)
      step("rand", ($urandom_range(3) == 0), 4'($urandom), ($urandom_range(3) != 0),
           2'($urandom), 4'($urandom));

    // Drive both counters toward saturation with taken B branches
    for (int unsigned r = 0; r < 20; r++)
      step("sat", 0, 4'b0000, 1, 2'b00, 4'd0);
    chk("sat.cnt1", 32'(cnt1), 32'd15);

    // Asynchronous reset with a branch pending at the next edge
    set_flags = 1; br_valid = 1; br_type = 2'b00;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst.cnt0", 32'(cnt0), 32'd0);
    @(posedge clk);
    #1;
    check_all("rst_held");
    #2;
    rst_n = 1'b1;
    step("after_rst", 0, 4'b0000, 0, 2'b00, 4'd0);
    chk("after_rst.tv", 32'(tv0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
